// File: rtl/tristate_regfile_pkg.sv
// Shared definitions for the tri-state register file and its TT wrapper.
// Contents:
//   state_t     - controller state encoding (IDLE=0, WRITE=1, RD_TURN=2, RD_DRIVE=3)
//   DEF_WIDTH   - default data / bus width
//   DEF_DEPTH   - default number of registers
package tristate_regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_TURN  = 2'd2,
    RD_DRIVE = 2'd3
  } state_t;

endpackage

// File: rtl/tristate_regfile_core.sv
// DEPTH x WIDTH register storage with one write port and two combinational
// read ports.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset (clears all regs)
//   we, waddr, wdata   - write port, captured on the rising edge
//   raddr_a / rdata_a  - read port used by the bus datapath
//   raddr_b / rdata_b  - read port used by the mirror output
module regfile_core
  import tristate_regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] regs [DEPTH];

  // Storage array: cleared on reset, single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/tristate_regfile.sv
// Addressed register file on a shared bidirectional bus, with optional
// auto-increment bursts and a one-cycle turnaround before the block drives.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   sel, r_nw    - transaction strobe; 1 = read (block drives), 0 = write
//   addr         - start address, sampled when a transaction starts
//   bus_in       - bus data into the block
//   bus_out      - registered bus data from the block
//   bus_oe       - registered per-bit output enable (all ones or all zeros)
//   mirror_sel   - register shown on mirror
//   mirror       - combinational view of regs[mirror_sel]
//   busy         - high whenever the controller is not idle
module tristate_regfile
  import tristate_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BURST_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              r_nw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  bus_in,
  output logic [WIDTH-1:0]  bus_out,
  output logic [WIDTH-1:0]  bus_oe,
  output logic [WIDTH-1:0]  mirror,
  input  logic [ADDR_W-1:0] mirror_sel,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
  localparam logic              BURST    = (BURST_EN != 0);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  bus_out_nxt;
  logic              oe;
  logic              oe_nxt;
  logic              we;

  assign ptr_inc = ptr + ADDR_ONE;
  // A transaction's first beat uses the live address; later beats use ptr.
  assign wr_addr = (state == IDLE) ? addr : ptr;

  regfile_core #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (wr_addr),
    .wdata   (bus_in),
    .raddr_a (rd_addr),
    .rdata_a (rd_data),
    .raddr_b (mirror_sel),
    .rdata_b (mirror)
  );

  // Datapath read address: start address in IDLE, next word while driving a burst
  always_comb begin
    rd_addr = ptr;
    case (state)
      IDLE:     rd_addr = addr;
      RD_DRIVE: rd_addr = BURST ? ptr_inc : ptr;
      default:  rd_addr = ptr;
    endcase
  end

  // Next-state, pointer, bus and write-enable decode
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    bus_out_nxt = bus_out;
    oe_nxt      = oe;
    we          = 1'b0;
    case (state)
      IDLE: begin
        oe_nxt = 1'b0;
        if (sel && !r_nw) begin
          we        = 1'b1;
          ptr_nxt   = BURST ? (addr + ADDR_ONE) : addr;
          state_nxt = WRITE;
        end else if (sel && r_nw) begin
          bus_out_nxt = rd_data;
          ptr_nxt     = addr;
          state_nxt   = RD_TURN;
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (sel && !r_nw) begin
          we      = 1'b1;
          ptr_nxt = BURST ? ptr_inc : ptr;
        end else begin
          // Direction change or deselect both end the burst; no write.
          state_nxt = IDLE;
        end
      end
      RD_TURN: begin
        // Bus stays undriven this cycle so the other side can release it.
        if (sel && r_nw) begin
          oe_nxt    = 1'b1;
          state_nxt = RD_DRIVE;
        end else begin
          oe_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      RD_DRIVE: begin
        if (sel && r_nw) begin
          ptr_nxt     = BURST ? ptr_inc : ptr;
          bus_out_nxt = rd_data;
        end else begin
          // Any write attempted here is dropped: we stays low.
          oe_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        oe_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Controller state, pointer and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= {ADDR_W{1'b0}};
      bus_out <= {WIDTH{1'b0}};
      oe      <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      bus_out <= bus_out_nxt;
      oe      <= oe_nxt;
    end
  end

  assign bus_oe = {WIDTH{oe}};
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_tristate_regfile.sv
// Self-checking bench: two instances (burst and fixed-pointer) share one
// stimulus stream and are compared each cycle against a transaction-level
// reference model, plus a table of hand-derived vectors and corner sequences.
module tb_tristate_regfile;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  localparam int T_NONE = 0;
  localparam int T_WR   = 1;
  localparam int T_RD   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel;
  logic          r_nw;
  logic [AW-1:0] addr;
  logic [AW-1:0] msel;
  logic [W-1:0]  din;
  logic [W-1:0]  out0, oe0, mir0, out1, oe1, mir1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  tristate_regfile #(.WIDTH(W), .DEPTH(D), .BURST_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .r_nw(r_nw), .addr(addr),
    .bus_in(din), .bus_out(out0), .bus_oe(oe0), .mirror(mir0),
    .mirror_sel(msel), .busy(busy0)
  );

  tristate_regfile #(.WIDTH(W), .DEPTH(D), .BURST_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .r_nw(r_nw), .addr(addr),
    .bus_in(din), .bus_out(out1), .bus_oe(oe1), .mirror(mir1),
    .mirror_sel(msel), .busy(busy1)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: index 0 = burst build, 1 = fixed-pointer build.
  logic [W-1:0] m_regs [2][D];
  int           m_txn   [2];
  int           m_cnt   [2];
  int           m_start [2];
  logic [W-1:0] m_out   [2];
  logic         m_oe    [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) m_regs[k][i] = '0;
      m_txn[k] = T_NONE; m_cnt[k] = 0; m_start[k] = 0;
      m_out[k] = '0; m_oe[k] = 1'b0;
    end
  endfunction

  // One clock edge of a transaction-level view: beat count from the start address.
  function automatic void model_edge(int k, bit burst, bit s, bit rnw, int a, logic [W-1:0] d);
    int ix;
    case (m_txn[k])
      T_NONE: begin
        if (s) begin
          m_start[k] = a;
          if (!rnw) begin
            m_regs[k][a] = d; m_txn[k] = T_WR; m_cnt[k] = 1;
          end else begin
            m_txn[k] = T_RD; m_cnt[k] = 0; m_out[k] = m_regs[k][a];
          end
        end
      end
      T_WR: begin
        if (s && !rnw) begin
          ix = burst ? (m_start[k] + m_cnt[k]) % D : m_start[k];
          m_regs[k][ix] = d; m_cnt[k]++;
        end else m_txn[k] = T_NONE;
      end
      T_RD: begin
        if (s && rnw) begin
          m_cnt[k]++; m_oe[k] = 1'b1;
          ix = burst ? (m_start[k] + m_cnt[k] - 1) % D : m_start[k];
          m_out[k] = m_regs[k][ix];
        end else begin
          m_oe[k] = 1'b0; m_txn[k] = T_NONE;
        end
      end
      default: m_txn[k] = T_NONE;
    endcase
  endfunction

  task automatic compare_all(input int ms);
    check("out0",  out0,  m_out[0]);
    check("oe0",   oe0,   {W{m_oe[0]}});
    check("busy0", busy0, m_txn[0] != T_NONE);
    check("mir0",  mir0,  m_regs[0][ms]);
    check("out1",  out1,  m_out[1]);
    check("oe1",   oe1,   {W{m_oe[1]}});
    check("busy1", busy1, m_txn[1] != T_NONE);
    check("mir1",  mir1,  m_regs[1][ms]);
  endtask

  // Called at a falling edge: drive, clock once, compare at next falling edge.
  task automatic step(input bit s, input bit rnw, input int a, input logic [W-1:0] d, input int ms);
    sel = s; r_nw = rnw; addr = AW'(a); din = d; msel = AW'(ms);
    @(posedge clk);
    model_edge(0, 1'b1, s, rnw, a, d);
    model_edge(1, 1'b0, s, rnw, a, d);
    @(negedge clk);
    compare_all(ms);
  endtask

  task automatic sweep_mirror(input string nm);
    for (int i = 0; i < D; i++) begin
      msel = AW'(i);
      #1;
      check({nm, "_m0"}, mir0, m_regs[0][i]);
      check({nm, "_m1"}, mir1, m_regs[1][i]);
    end
  endtask

  typedef struct {
    bit         s;
    bit         rnw;
    int         a;
    logic [7:0] d;
    int         ms;
    logic [7:0] e_out;
    bit         e_oe;
    bit         e_busy;
    logic [7:0] e_mir;
  } vec_t;

  vec_t vt [14];

  initial begin
    bit rs, rr;
    // Hand-derived expectations for the burst build, starting from reset.
    vt[0]  = '{1'b1, 1'b0, 2, 8'hA5, 2, 8'h00, 1'b0, 1'b1, 8'hA5};
    vt[1]  = '{1'b0, 1'b0, 0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 0, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 1'b0, 3, 8'h11, 3, 8'h00, 1'b0, 1'b1, 8'h11};
    vt[4]  = '{1'b1, 1'b0, 0, 8'h22, 0, 8'h00, 1'b0, 1'b1, 8'h22};
    vt[5]  = '{1'b1, 1'b0, 0, 8'h33, 1, 8'h00, 1'b0, 1'b1, 8'h33};
    vt[6]  = '{1'b1, 1'b0, 0, 8'h44, 2, 8'h00, 1'b0, 1'b1, 8'h44};
    vt[7]  = '{1'b0, 1'b0, 0, 8'h00, 3, 8'h00, 1'b0, 1'b0, 8'h11};
    vt[8]  = '{1'b1, 1'b1, 1, 8'h00, 0, 8'h33, 1'b0, 1'b1, 8'h22};
    vt[9]  = '{1'b1, 1'b1, 0, 8'h00, 0, 8'h33, 1'b1, 1'b1, 8'h22};
    vt[10] = '{1'b1, 1'b1, 0, 8'h00, 0, 8'h44, 1'b1, 1'b1, 8'h22};
    vt[11] = '{1'b1, 1'b1, 0, 8'h00, 0, 8'h11, 1'b1, 1'b1, 8'h22};
    vt[12] = '{1'b1, 1'b0, 0, 8'hEE, 2, 8'h11, 1'b0, 1'b0, 8'h44};
    vt[13] = '{1'b0, 1'b0, 0, 8'h00, 0, 8'h11, 1'b0, 1'b0, 8'h22};

    rst_n = 1'b0; sel = 1'b0; r_nw = 1'b0; addr = '0; din = '0; msel = '0;
    model_reset();
    #3;
    check("rst_out0", out0, 8'h00);
    check("rst_oe0",  oe0,  8'h00);
    check("rst_busy0", busy0, 1'b0);
    check("rst_out1", out1, 8'h00);
    check("rst_oe1",  oe1,  8'h00);
    sweep_mirror("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      step(vt[i].s, vt[i].rnw, vt[i].a, vt[i].d, vt[i].ms);
      check($sformatf("v%0d_out", i),  out0,  vt[i].e_out);
      check($sformatf("v%0d_oe", i),   oe0,   {W{vt[i].e_oe}});
      check($sformatf("v%0d_busy", i), busy0, vt[i].e_busy);
      check($sformatf("v%0d_mir", i),  mir0,  vt[i].e_mir);
    end
    // The dropped 0xEE write must not appear anywhere.
    for (int i = 0; i < D; i++) begin
      msel = AW'(i);
      #1;
      check($sformatf("no_ee_%0d", i), mir0 == 8'hEE, 1'b0);
    end
    sweep_mirror("post_tbl");
    @(negedge clk);

    // Asynchronous reset in the middle of a driven read.
    step(1'b1, 1'b1, 2, 8'h00, 0);
    step(1'b1, 1'b1, 0, 8'h00, 0);
    check("pre_rst_oe", oe0, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_oe0", oe0, 8'h00);
    check("arst_oe1", oe1, 8'h00);
    check("arst_busy0", busy0, 1'b0);
    check("arst_out0", out0, 8'h00);
    model_reset();
    sweep_mirror("arst");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1, 8'h5A, 1);
    check("post_rst_busy", busy0, 1'b1);
    check("post_rst_mir", mir0, 8'h5A);
    step(1'b0, 1'b0, 0, 8'h00, 1);

    // Fixed-pointer build: a held write keeps hitting the start address.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 1, 8'h01, 1);
    step(1'b1, 1'b0, 1, 8'h02, 1);
    step(1'b1, 1'b0, 1, 8'h03, 1);
    step(1'b0, 1'b0, 0, 8'h00, 1);
    check("nb_r1", mir1, 8'h03);
    for (int i = 0; i < D; i++) begin
      if (i != 1) begin
        msel = AW'(i);
        #1;
        check($sformatf("nb_r%0d", i), mir1, 8'h00);
      end
    end
    @(negedge clk);
    step(1'b1, 1'b1, 0, 8'h00, 0);
    step(1'b1, 1'b1, 0, 8'h00, 0);
    check("nb_rd_out", out1, 8'h00);
    check("nb_rd_oe",  oe1,  8'hFF);
    step(1'b1, 1'b1, 0, 8'h00, 0);
    step(1'b0, 1'b0, 0, 8'h00, 0);

    // Randomised traffic with sticky direction so bursts form.
    rr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rs = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) rr = ~rr;
      step(rs, rr, int'($urandom_range(D - 1)), W'($urandom), int'($urandom_range(D - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
